prim_cmd_queue: RTL and testbench
=================================

# prim_cmd_queue

Command queue and dispatcher directly upstream of the primitive renderer. It buffers 16-bit primitive commands written by the host register interface: coordinate, colour and execute words, with the opcode in bits [15:12]. It drives the renderer's `cmd_i`/`cmd_valid_i` pair. Each execute word is held until the renderer has started and then finished the previous primitive, so coordinates for the next primitive can be queued at full host speed without corrupting a draw in progress.

## Interface
Parameters:
- `DEPTH`, 16: queue entries; power of two, 4..256.
- `GUARD_CYCLES`, 3: cycles after an execute dispatch during which `busy_i` is ignored, covering the renderer's start-to-busy latency; minimum 1.

Ports:
- `clk`  in  1  system clock.
- `reset_n_i`  in  1  asynchronous active-low reset.
- `wr_i`  in  1  host write strobe, one entry per cycle.
- `data_i`  in  16  command word.
- `flush_i`  in  1  synchronous flush: empty the queue, abort dispatch, clear `overflow_o`.
- `rndr_busy_i`  in  1  renderer busy (the renderer's `busy_o`).
- `cmd_o`  out  16  command to the renderer.
- `cmd_valid_o`  out  1  `cmd_o` is valid this cycle (one-cycle pulse per command).
- `full_o`  out  1  queue holds DEPTH entries.
- `empty_o`  out  1  queue holds 0 entries.
- `level_o`  out  $clog2(DEPTH)+1  current entry count.
- `overflow_o`  out  1  sticky: a write was dropped.
- `busy_o`  out  1  queue non-empty, or state not IDLE, or `rndr_busy_i`.

## Operation
- Storage is a circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a count register.
- Accepted write: `wr_i && !full_o`. Data is stored at the write pointer; the pointer and count increment.
- Write while full: the data is dropped, `overflow_o` is set, and no state changes. This holds even if a pop occurs in the same cycle, because `full_o` is registered.
- Simultaneous accepted write and pop: count is unchanged and both pointers advance.
- There is no fall-through. A write into an empty queue is visible to the dispatcher the next cycle.
- Dispatcher FSM:
  - IDLE: if `!empty_o && !rndr_busy_i`, pop the head, register `cmd_o <= head`, pulse `cmd_valid_o`. If `head[15:12] == xv::PR_EXECUTE`, load the guard counter with GUARD_CYCLES-1 and go to GUARD; otherwise stay in IDLE, so non-execute words can dispatch back-to-back, one per cycle.
  - GUARD: decrement the counter and ignore `rndr_busy_i`; at 0 go to WAIT_BUSY.
  - WAIT_BUSY: when `rndr_busy_i == 0`, go to IDLE. A command issued from IDLE in that next cycle is the earliest possible dispatch.
- A non-execute word dispatches only while the renderer is not busy. Coordinates are never altered mid-draw.
- Execute words with unsupported sub-opcodes are dispatched and guarded identically; the renderer ignores them.
- `flush_i` has priority over `wr_i` and dispatch in the same cycle:
  - pointers and count go to 0, state goes to IDLE, `overflow_o` clears;
  - `cmd_valid_o` is 0 in the following cycle, and a write in the flush cycle is discarded.

## Timing
- Reset (async assert, sync release):
  - `cmd_o=0`, `cmd_valid_o=0`, `full_o=0`, `empty_o=1`, `level_o=0`, `overflow_o=0`, `busy_o=0`;
  - state IDLE, pointers 0.
- `busy_o` is combinational from registered state and `rndr_busy_i`.
- Latency: write accepted at edge N, entry counted at N+1, `cmd_valid_o` high at N+2 when idle.
- `cmd_valid_o` is high for exactly one cycle per popped entry.
- After an execute dispatch at cycle D, the earliest next dispatch is cycle D+GUARD_CYCLES+1, and only if `rndr_busy_i` is low from cycle D+GUARD_CYCLES.
- Reset mid-draw: the queue empties immediately. The renderer is reset by the same system reset.

## Configuration
- `PRIM_CMDQ_STATS_EN` defined:
  - adds output `exec_count_o` [15:0], which counts dispatched execute words;
  - the counter wraps 0xFFFF to 0, clears on reset and on `flush_i`.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset, then write 0x1005 at cycle 0 with renderer idle: `cmd_o=0x1005` and `cmd_valid_o=1` at cycle 2 only; `level_o` returns to 0; `empty_o=1`.
- Write 6 coordinate words plus 0xF000 (line execute) back-to-back, renderer idle: 7 consecutive `cmd_valid_o` pulses in order. Then, with a renderer model holding busy for 20 cycles starting 2 cycles after execute, a following 0x1010 dispatches exactly 1 cycle after busy falls.
- DEPTH=16, `rndr_busy_i=1`, 17 writes: `full_o=1` after the 16th, `overflow_o=1` after the 17th, 17th data never appears; `level_o=16`.
- Fill 5 entries with busy held, assert `flush_i` together with a write: next cycle `level_o=0`, `overflow_o=0`, no `cmd_valid_o` after busy drops.
- Execute with GUARD_CYCLES=3 and `rndr_busy_i` never asserted: next queued word dispatches at D+4.
- `reset_n_i` pulsed low mid-queue (level 8, state GUARD): all outputs at reset values asynchronously, dispatch resumes only on new writes; with `PRIM_CMDQ_STATS_EN`, 3 executes give `exec_count_o=3`.

Source files
------------

// File: rtl/prim_cmd_queue.sv
// prim_cmd_queue: circular command buffer and dispatcher feeding the primitive renderer.
// Optional PRIM_CMDQ_STATS_EN adds exec_count_o, a wrapping count of dispatched execute words.
module prim_cmd_queue #(
  parameter int DEPTH        = 16,
  parameter int GUARD_CYCLES = 3
) (
  input  logic                     clk,
  input  logic                     reset_n_i,
  input  logic                     wr_i,
  input  logic [15:0]              data_i,
  input  logic                     flush_i,
  input  logic                     rndr_busy_i,
  output logic [15:0]              cmd_o,
  output logic                     cmd_valid_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o,
`ifdef PRIM_CMDQ_STATS_EN
  output logic [15:0]              exec_count_o,
`endif
  output logic                     busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam logic [3:0] PR_EXECUTE = 4'hF;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GUARD     = 2'd1,
    WAIT_BUSY = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   guard_q, guard_d;
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     cmd_q, cmd_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic [15:0]     mem_q [DEPTH];
  logic [15:0]     head;
  logic            full, empty, push, pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rptr_q];

  // Flush wins over both the host write and a dispatch in the same cycle.
  assign push = wr_i && !full && !flush_i;
  assign pop  = (state_q == IDLE) && !empty && !rndr_busy_i && !flush_i;

  always_comb begin
    state_d     = state_q;
    guard_d     = guard_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          cmd_d       = head;
          cmd_valid_d = 1'b1;
          if (head[15:12] == PR_EXECUTE) begin
            guard_d = GW'(GUARD_CYCLES - 1);
            state_d = (GUARD_CYCLES == 1) ? WAIT_BUSY : GUARD;
          end
        end
      end
      // Renderer busy is not yet trustworthy here; just count down the start latency.
      GUARD: begin
        guard_d = guard_q - GW'(1);
        if (guard_q <= GW'(1)) begin
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (!rndr_busy_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d = IDLE;
      guard_d = '0;
    end
  end

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush_i) begin
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      if (wr_i && full) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      guard_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      guard_q     <= guard_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
    end
  end

  // Storage needs no reset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= data_i;
    end
  end

`ifdef PRIM_CMDQ_STATS_EN
  logic [15:0] exec_count_q, exec_count_d;

  always_comb begin
    exec_count_d = exec_count_q;
    if (flush_i) begin
      exec_count_d = '0;
    end else if (pop && (head[15:12] == PR_EXECUTE)) begin
      exec_count_d = exec_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      exec_count_q <= '0;
    end else begin
      exec_count_q <= exec_count_d;
    end
  end

  assign exec_count_o = exec_count_q;
`endif

  assign cmd_o       = cmd_q;
  assign cmd_valid_o = cmd_valid_q;
  assign full_o      = full;
  assign empty_o     = empty;
  assign level_o     = count_q;
  assign overflow_o  = overflow_q;
  assign busy_o      = !empty || (state_q != IDLE) || rndr_busy_i;

endmodule

// File: tb/tb_prim_cmd_queue.sv
// Testbench for prim_cmd_queue: directed and randomized stimulus checked against a queue-based model.
// Covers exec_count_o as well when PRIM_CMDQ_STATS_EN is defined.
module tb_prim_cmd_queue;

  localparam int DEPTH = 16;
  localparam int G     = 3;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n_i;
  logic          wr_i;
  logic [15:0]   data_i;
  logic          flush_i;
  logic          rndr_busy_i;
  logic [15:0]   cmd_o;
  logic          cmd_valid_o;
  logic          full_o;
  logic          empty_o;
  logic [LW-1:0] level_o;
  logic          overflow_o;
  logic          busy_o;
`ifdef PRIM_CMDQ_STATS_EN
  logic [15:0]   exec_count_o;
`endif

  always #5 clk = ~clk;

  prim_cmd_queue #(.DEPTH(DEPTH), .GUARD_CYCLES(G)) dut (
    .clk          (clk),
    .reset_n_i    (reset_n_i),
    .wr_i         (wr_i),
    .data_i       (data_i),
    .flush_i      (flush_i),
    .rndr_busy_i  (rndr_busy_i),
    .cmd_o        (cmd_o),
    .cmd_valid_o  (cmd_valid_o),
    .full_o       (full_o),
    .empty_o      (empty_o),
    .level_o      (level_o),
    .overflow_o   (overflow_o),
`ifdef PRIM_CMDQ_STATS_EN
    .exec_count_o (exec_count_o),
`endif
    .busy_o       (busy_o)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: the queue contents plus a "dispatch locked" flag for the execute rule.
  logic [15:0] mq[$];
  logic        mOverflow, mValid, mLocked;
  logic [15:0] mCmd, mExecCount;
  int          mExecCyc, cyc;

  logic        rndrAuto;
  int          busyStart, busyEnd, lastExecCyc;
  logic [15:0] watchWord;
  int          seenCyc;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s cycle=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mOverflow  = 1'b0;
    mValid     = 1'b0;
    mLocked    = 1'b0;
    mCmd       = 16'h0;
    mExecCount = 16'h0;
    mExecCyc   = -100;
    busyStart  = -100;
    busyEnd    = -100;
  endtask

  // One clock of the rules: an execute dispatched at D blocks dispatch until the cycle after
  // the first cycle c >= D+G in which the renderer is idle.
  task automatic modelStep();
    logic [15:0] head;
    bit canPop, wasFull;
    if (flush_i) begin
      mq.delete();
      mOverflow  = 1'b0;
      mValid     = 1'b0;
      mLocked    = 1'b0;
      mExecCount = 16'h0;
    end else begin
      canPop  = !mLocked && (mq.size() > 0) && !rndr_busy_i;
      wasFull = (mq.size() == DEPTH);
      if (mLocked && (cyc >= mExecCyc + G) && !rndr_busy_i) mLocked = 1'b0;
      mValid = 1'b0;
      if (canPop) begin
        head   = mq.pop_front();
        mCmd   = head;
        mValid = 1'b1;
        if (head[15:12] == 4'hF) begin
          mLocked     = 1'b1;
          mExecCyc    = cyc;
          lastExecCyc = cyc;
          mExecCount  = mExecCount + 16'd1;
          busyStart   = cyc + 2;
          busyEnd     = cyc + 22;
        end
      end
      if (wr_i) begin
        if (wasFull) mOverflow = 1'b1;
        else         mq.push_back(data_i);
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("cmd_valid", 32'(cmd_valid_o), 32'(mValid));
    checkOutput("cmd", 32'(cmd_o), 32'(mCmd));
    checkOutput("level", 32'(level_o), 32'(mq.size()));
    checkOutput("full", 32'(full_o), 32'(mq.size() == DEPTH));
    checkOutput("empty", 32'(empty_o), 32'(mq.size() == 0));
    checkOutput("overflow", 32'(overflow_o), 32'(mOverflow));
    checkOutput("busy", 32'(busy_o), 32'((mq.size() != 0) || mLocked || rndr_busy_i));
`ifdef PRIM_CMDQ_STATS_EN
    checkOutput("exec_count", 32'(exec_count_o), 32'(mExecCount));
`endif
  endtask

  task automatic applyStimulus(input logic wr, input logic [15:0] data, input logic flush,
                               input logic busyForce);
    wr_i        = wr;
    data_i      = data;
    flush_i     = flush;
    rndr_busy_i = busyForce | (rndrAuto && (cyc >= busyStart) && (cyc < busyEnd));
    @(posedge clk);
    modelStep();
    cyc++;
    #1;
    checkAll();
    if ((cmd_valid_o === 1'b1) && (cmd_o === watchWord) && (seenCyc < 0)) seenCyc = cyc;
  endtask

  task automatic idle(input int n, input logic busyForce);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0, 1'b0, busyForce);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout cycle=%0d", cyc);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int w;
    logic [15:0] d;
    reset_n_i   = 1'b0;
    wr_i        = 1'b0;
    data_i      = 16'h0;
    flush_i     = 1'b0;
    rndr_busy_i = 1'b0;
    rndrAuto    = 1'b0;
    cyc         = 0;
    lastExecCyc = -100;
    watchWord   = 16'hFFFF;
    seenCyc     = -1;
    modelReset();
    #12;
    checkAll();
    @(negedge clk);
    reset_n_i = 1'b1;

    $display("[TB] single word latency");
    watchWord = 16'h1005;
    seenCyc   = -1;
    w         = cyc;
    applyStimulus(1'b1, 16'h1005, 1'b0, 1'b0);
    idle(4, 1'b0);
    checkOutput("latency_1005", 32'(seenCyc), 32'(w + 2));

    $display("[TB] coordinates, execute, renderer busy window");
    rndrAuto = 1'b1;
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 16'h1100 + 16'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hF000, 1'b0, 1'b0);
    watchWord = 16'h1010;
    seenCyc   = -1;
    applyStimulus(1'b1, 16'h1010, 1'b0, 1'b0);
    idle(30, 1'b0);
    checkOutput("after_busy_1010", 32'(seenCyc), 32'(busyEnd + 2));
    rndrAuto = 1'b0;

    $display("[TB] overflow with renderer busy");
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 16'h2000 + 16'(i), 1'b0, 1'b1);
    checkOutput("level_full", 32'(level_o), 32'(DEPTH));
    checkOutput("overflow_set", 32'(overflow_o), 32'd1);
    watchWord = 16'h2010;
    seenCyc   = -1;
    idle(20, 1'b0);
    checkOutput("dropped_word_absent", 32'(seenCyc), 32'hFFFF_FFFF);

    $display("[TB] flush with write");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'h1200 + 16'(i), 1'b0, 1'b1);
    applyStimulus(1'b1, 16'h1299, 1'b1, 1'b1);
    checkOutput("flush_level", 32'(level_o), 32'd0);
    checkOutput("flush_overflow", 32'(overflow_o), 32'd0);
    idle(5, 1'b0);

    $display("[TB] guard without renderer busy");
    watchWord = 16'h1234;
    seenCyc   = -1;
    applyStimulus(1'b1, 16'hF001, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0);
    idle(8, 1'b0);
    checkOutput("guard_gap", 32'(seenCyc), 32'(lastExecCyc + G + 2));

    $display("[TB] reset mid-queue");
    applyStimulus(1'b1, 16'hF000, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 16'h3000 + 16'(i), 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("pre_reset_level", 32'(level_o), 32'd8);
    #2;
    reset_n_i = 1'b0;
    modelReset();
    #1;
    checkAll();
    @(negedge clk);
    reset_n_i = 1'b1;
    idle(6, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 16'hF000 + 16'(i), 1'b0, 1'b0);
      idle(6, 1'b0);
    end
`ifdef PRIM_CMDQ_STATS_EN
    checkOutput("exec_count_3", 32'(exec_count_o), 32'd3);
`endif

    $display("[TB] randomized traffic");
    rndrAuto = 1'b1;
    for (int i = 0; i < 400; i++) begin
      d[15:12] = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      d[11:0]  = 12'($urandom);
      applyStimulus(logic'($urandom_range(0, 99) < 60), d,
                    logic'($urandom_range(0, 79) == 0),
                    logic'($urandom_range(0, 9) == 0));
    end
    rndrAuto = 1'b0;
    idle(40, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
